simple_dp_scheduler: RTL and testbench
======================================

Name: simple_dp_scheduler

Overview:
- Round-robin scheduler that shares one instance of the simple NAND/NOR/DFF/INV datapath among NUM_REQ requesters.
- Each requester offers a 1-bit operand pair (a,b) under valid/ready. The scheduler drives the datapath inputs inp1/inp2 and tags every issued operation with the requester ID. The registered datapath result `out` is routed back to the owning requester after DP_LAT cycles.
- It sits between the requester logic and the datapath, and is clocked by the same tau2015_clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must satisfy 2**ID_W >= NUM_REQ.
- DP_LAT, 1, cycles from driving inp1/inp2 to a valid `out` (1..4).

Ports:
- tau2015_clk  in  1  sole clock, rising edge.
- tau2015_rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = issue permitted; 0 = finish in-flight ops, then idle.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ  per-requester operand a.
- req_b  in  NUM_REQ  per-requester operand b.
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid&ready.
- dp_inp1  out  1  to datapath inp1.
- dp_inp2  out  1  to datapath inp2.
- dp_out  in  1  from datapath out.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse: result for that requester.
- rsp_data  out  1  result bit; qualified by rsp_valid.
- rsp_id  out  ID_W  ID of the current response.
- busy  out  1  1 while any op is in flight or state != IDLE.

Behaviour:
Reset:
- Asynchronous assert when tau2015_rst_n=0; synchronous deassert with the first rising edge after release.
- All outputs are 0 on reset.
- rr_ptr resets to 0; the tag pipeline is cleared.
- Reset mid-operation discards in-flight tags; no rsp_valid is produced for them.

FSM states: IDLE, RUN, DRAIN.
- IDLE -> RUN when enable=1.
- RUN -> DRAIN when enable=0.
- DRAIN -> IDLE when the tag pipeline is empty.
- DRAIN -> RUN if enable returns to 1 before empty.

Arbitration (RUN only):
- Combinational grant: the first requester with req_valid=1, searching from rr_ptr upward modulo NUM_REQ.
- At most one req_ready bit is high per cycle. No ready is asserted in IDLE or DRAIN.
- On handshake, rr_ptr <= (granted ID + 1) mod NUM_REQ. With no handshake, rr_ptr holds.

Issue:
- dp_inp1 and dp_inp2 are registered. On a handshake at edge t they take req_a/req_b of the granter, so they are visible in cycle t+1.
- On a non-issue cycle both are driven 0. The datapath then computes n1=1, n2=0, so its flop clears: an idle cycle resets datapath state to 0.

Tag pipeline:
- DP_LAT+1 stages of {valid, id}. Stage 0 is loaded at the issue edge.
- When the last stage is valid, that cycle samples dp_out: rsp_valid[id]=1, rsp_id=id, rsp_data=dp_out.
- Response latency is exactly DP_LAT+1 cycles after the handshake edge.
- rsp_data and rsp_id are 0 when no response is active.

Throughput and ordering:
- One issue per cycle and one response per cycle; responses return in issue order.

Datapath reference model (the bench uses this):
- q_next = (a & b) & ~q, and out = q.
- Back-to-back issues are therefore state-dependent, and that is intentional. Requesters needing a fresh result insert one idle cycle.

Simultaneous events:
- enable falling in the same cycle as a valid grant: the handshake is allowed, and DRAIN starts next cycle.
- busy = (state != IDLE) | any tag-pipeline valid.

Optional Feature:
Macro: SIMPLE_DP_SCHED_AGE_EN.
- When defined: each requester has a 4-bit wait counter.
  - It increments on each RUN cycle where req_valid=1 and no handshake, saturating at 15.
  - It clears on that requester's handshake.
  - Any requester whose counter reaches 8 overrides round-robin; the lowest ID among such requesters wins. rr_ptr updates as normal after the grant.
- When undefined: pure round-robin; no counters are synthesised.

Test Plan:
- Reset mid-run: issue from req0 with a=b=1, then pull tau2015_rst_n low one cycle later -> all outputs 0 immediately, no rsp_valid after release, rr_ptr=0.
- Single op: enable=1, req_valid=0001, a=b=1, datapath flop=0 -> dp_inp1/dp_inp2=1 one cycle after the handshake; rsp_valid=0001, rsp_data=1, rsp_id=0 exactly DP_LAT+1 cycles after the handshake.
- Round-robin fairness: req_valid=1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses arrive in the same order with correct rsp_id.
- State dependence: req0 issues a=b=1 twice back-to-back -> rsp_data 1 then 0. Repeating with an idle cycle between them -> 1 then 1.
- Drain: drop enable with 2 ops in flight -> req_ready=0 immediately; both responses delivered; busy falls the cycle after the last rsp_valid; state IDLE.
- AGE_EN:
  - Stimulus: req3 held valid while req0..2 saturate.
  - Expectation: under round-robin req3 normally wins within 4 cycles. Force starvation by gating enable pulses; once req3's wait counter reaches 8, req3 is granted next.
  - Without the macro, the same stimulus follows pure round-robin.

Source files
------------

// File: rtl/simple_dp_scheduler.sv
// Round-robin scheduler sharing one NAND/NOR/DFF/INV datapath among NUM_REQ requesters.
// Optional aging override enabled by defining SIMPLE_DP_SCHED_AGE_EN.
module simple_dp_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DP_LAT  = 1
) (
  input  logic               tau2015_clk,
  input  logic               tau2015_rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_a,
  input  logic [NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0] req_ready,
  output logic               dp_inp1,
  output logic               dp_inp2,
  input  logic               dp_out,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  logic [ID_W:0]     rr_sum;
  logic              issue;
  logic              tags_busy;
  logic              tag_vld_p [DP_LAT+1];
  logic [ID_W-1:0]   tag_id_p  [DP_LAT+1];

`ifdef SIMPLE_DP_SCHED_AGE_EN
  logic [3:0]         age_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] aged;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) aged[i] = req_valid[i] & age_cnt[i][3];
  end

  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) age_cnt[i] <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && (grant_id == ID_W'(i))) age_cnt[i] <= '0;
        else if (req_valid[i] && (age_cnt[i] != 4'd15)) age_cnt[i] <= age_cnt[i] + 4'd1;
      end
    end
  end
`endif

  // Search from rr_ptr upward with wrap; an aged requester (lowest ID) overrides.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    rr_sum      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (rr_sum >= (ID_W+1)'(NUM_REQ)) rr_sum = rr_sum - (ID_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[rr_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = rr_sum[ID_W-1:0];
      end
    end
`ifdef SIMPLE_DP_SCHED_AGE_EN
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      if (aged[i]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
`endif
  end

  assign issue = (state == RUN) && grant_found;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) req_ready[i] = issue && (grant_id == ID_W'(i));
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k <= DP_LAT; k++) tags_busy = tags_busy | tag_vld_p[k];
  end

  assign busy = (state != IDLE) | tags_busy;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN:   if (enable) state_nxt = RUN;
               else if (!tags_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (issue) rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
    end
  end

  // Stage p0: operands to the datapath; idle cycles drive 0 so the datapath flop clears.
  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      dp_inp1 <= 1'b0;
      dp_inp2 <= 1'b0;
    end else begin
      dp_inp1 <= issue & req_a[grant_id];
      dp_inp2 <= issue & req_b[grant_id];
    end
  end

  // Stages p0..pDP_LAT: tag follows the operation through the datapath.
  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      for (int k = 0; k <= DP_LAT; k++) tag_vld_p[k] <= 1'b0;
    end else begin
      tag_vld_p[0] <= issue;
      for (int k = 1; k <= DP_LAT; k++) tag_vld_p[k] <= tag_vld_p[k-1];
    end
  end

  always_ff @(posedge tau2015_clk) begin
    tag_id_p[0] <= grant_id;
    for (int k = 1; k <= DP_LAT; k++) tag_id_p[k] <= tag_id_p[k-1];
  end

  // Response stage: sample dp_out while the last tag stage is valid.
  always_ff @(posedge tau2015_clk or negedge tau2015_rst_n) begin
    if (!tau2015_rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_data  <= 1'b0;
      rsp_id    <= '0;
      if (tag_vld_p[DP_LAT]) begin
        for (int i = 0; i < NUM_REQ; i++) rsp_valid[i] <= (tag_id_p[DP_LAT] == ID_W'(i));
        rsp_data <= dp_out;
        rsp_id   <= tag_id_p[DP_LAT];
      end
    end
  end

endmodule

// File: tb/tb_simple_dp_scheduler.sv
// Bench for simple_dp_scheduler: operation-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_simple_dp_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int DP_LAT  = 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_a = '0;
  logic [NUM_REQ-1:0] req_b = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic               dp_inp1, dp_inp2, dp_out;
  logic [NUM_REQ-1:0] rsp_valid;
  logic               rsp_data;
  logic [ID_W-1:0]    rsp_id;
  logic               busy;

  always #5 clk = ~clk;

  simple_dp_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DP_LAT(DP_LAT)) dut (
    .tau2015_clk(clk), .tau2015_rst_n(rst_n), .enable(enable),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .dp_inp1(dp_inp1), .dp_inp2(dp_inp2), .dp_out(dp_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  // Datapath stand-in: q_next = (a & b) & ~q, out delayed to DP_LAT cycles.
  logic dp_pipe [DP_LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= (dp_inp1 & dp_inp2) & ~dp_pipe[0];
    for (int k = 1; k < DP_LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign dp_out = dp_pipe[DP_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operation queue with due cycles.
  typedef struct { int id; bit res; int due; } op_t;
  op_t q_ops[$];
  int  m_mode;
  int  m_ptr;
  bit  m_inp1, m_inp2;
  int  last_issue;
  bit  last_res;
  int  cyc = 0;
  int  m_age [NUM_REQ];

  always @(negedge clk) begin
    int gid, idx;
    bit found, inflight, r;
    logic [NUM_REQ-1:0] exp_ready, exp_rv;
    bit exp_rd;
    int exp_id;
    op_t op;
    if (!rst_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_inp", {dp_inp1, dp_inp2}, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp", {rsp_data, rsp_id}, 0);
      chk("rst_busy", busy, 0);
      q_ops.delete();
      m_mode = 0; m_ptr = 0; m_inp1 = 0; m_inp2 = 0;
      last_issue = -100; last_res = 0;
      for (int k = 0; k < NUM_REQ; k++) m_age[k] = 0;
    end else begin
      found = 0; gid = 0;
      if (m_mode == 1) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (m_ptr + k) % NUM_REQ;
          if (!found && req_valid[idx]) begin found = 1; gid = idx; end
        end
`ifdef SIMPLE_DP_SCHED_AGE_EN
        for (int k = NUM_REQ-1; k >= 0; k--)
          if (req_valid[k] && m_age[k] >= 8) begin found = 1; gid = k; end
`endif
      end
      exp_ready = found ? NUM_REQ'(1) << gid : '0;
      inflight = 0;
      foreach (q_ops[j]) if (q_ops[j].due > cyc) inflight = 1;
      exp_rv = '0; exp_rd = 0; exp_id = 0;
      if (q_ops.size() > 0 && q_ops[0].due == cyc) begin
        op = q_ops.pop_front();
        exp_rv = NUM_REQ'(1) << op.id; exp_rd = op.res; exp_id = op.id;
      end
      chk("ready", req_ready, exp_ready);
      chk("dp_inp1", dp_inp1, m_inp1);
      chk("dp_inp2", dp_inp2, m_inp2);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("rsp_data", rsp_data, exp_rd);
      chk("rsp_id", rsp_id, exp_id);
      chk("busy", busy, (m_mode != 0) || inflight);
      if (found) begin
        r = req_a[gid] & req_b[gid] & ~((last_issue == cyc) ? last_res : 1'b0);
        last_issue = cyc + 1; last_res = r;
        q_ops.push_back('{id: gid, res: r, due: cyc + DP_LAT + 2});
        m_ptr = (gid + 1) % NUM_REQ;
        m_inp1 = req_a[gid]; m_inp2 = req_b[gid];
      end else begin
        m_inp1 = 0; m_inp2 = 0;
      end
      if (m_mode == 1)
        for (int k = 0; k < NUM_REQ; k++) begin
          if (found && k == gid) m_age[k] = 0;
          else if (req_valid[k] && m_age[k] < 15) m_age[k]++;
        end
      case (m_mode)
        0: if (enable) m_mode = 1;
        1: if (!enable) m_mode = 2;
        default: if (enable) m_mode = 1; else if (!inflight) m_mode = 0;
      endcase
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((req_ready & mask) != 0) break;
      tick();
    end
    chk("wait_ready", ((req_ready & mask) != 0), 1);
  endtask

  initial begin
    int since3, max_since3, grants3;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_inp1", dp_inp1, 0);
    chk("reset_rsp", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single operation from req0 with a=b=1
    repeat (2) tick();
    enable = 1; req_valid = 4'b0001; req_a = 4'b1111; req_b = 4'b1111;
    wait_ready(4'b0001); tick();
    req_valid = 0;
    chk("single_inp1", dp_inp1, 1);
    chk("single_inp2", dp_inp2, 1);
    repeat (DP_LAT) tick();
    chk("single_early", rsp_valid, 0);
    tick();
    chk("single_rsp_valid", rsp_valid, 4'b0001);
    chk("single_rsp_data", rsp_data, 1);
    chk("single_rsp_id", rsp_id, 0);

    // Back-to-back: 1 then 0
    repeat (3) tick();
    req_valid = 4'b0001; wait_ready(4'b0001); tick();
    #1 chk("b2b_ready", req_ready, 4'b0001);
    tick(); req_valid = 0;
    repeat (DP_LAT) tick();
    chk("b2b_first", rsp_data, 1);
    tick();
    chk("b2b_second_valid", rsp_valid, 4'b0001);
    chk("b2b_second", rsp_data, 0);

    // Idle cycle between: 1 then 1
    repeat (3) tick();
    req_valid = 4'b0001; wait_ready(4'b0001); tick();
    req_valid = 0; tick();
    req_valid = 4'b0001;
    #1 chk("gap_ready", req_ready, 4'b0001);
    tick(); req_valid = 0;
    repeat (DP_LAT - 1) tick();
    chk("gap_first", {rsp_valid, rsp_data}, {4'b0001, 1'b1});
    repeat (2) tick();
    chk("gap_second", {rsp_valid, rsp_data}, {4'b0001, 1'b1});

    // Reset mid-run
    repeat (3) tick();
    req_valid = 4'b0001; wait_ready(4'b0001); tick();
    req_valid = 0; rst_n = 0;
    #1;
    chk("midrst_inp", {dp_inp1, dp_inp2}, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", req_ready, 0);
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      chk("midrst_no_rsp", rsp_valid, 0);
      tick();
    end

    // Round-robin fairness from rr_ptr=0
    req_a = '0; req_b = '0; req_valid = 4'b1111;
    wait_ready(4'b1111);
    for (int k = 0; k < 8; k++) begin
      chk("rr_grant", req_ready, 4'b0001 << (k % 4));
      tick();
    end
    req_valid = 0;

    // Drain with two ops in flight
    repeat (4) tick();
    req_a = 4'b1111; req_b = 4'b1111; req_valid = 4'b0011;
    wait_ready(4'b1111); tick();
    enable = 0;
    #1 chk("drain_same_cycle", req_ready, 4'b0010);
    tick();
    #1 chk("drain_ready_off", req_ready, 0);
    repeat (DP_LAT) tick();
    chk("drain_rsp0", {rsp_valid, 2'(rsp_id)}, {4'b0001, 2'd0});
    tick();
    chk("drain_rsp1", {rsp_valid, 2'(rsp_id)}, {4'b0010, 2'd1});
    chk("drain_busy_hold", busy, 1);
    tick();
    chk("drain_busy_fall", busy, 0);
    chk("drain_rsp_done", rsp_valid, 0);
    req_valid = 0;

    // req3 held valid while others contend, enable pulsed
    since3 = 0; max_since3 = 0; grants3 = 0;
    for (int i = 0; i < 60; i++) begin
      enable = ($urandom_range(0, 3) != 0);
      req_valid = 4'b1000 | 4'($urandom_range(0, 7));
      req_a = 4'($urandom); req_b = 4'($urandom);
      #1;
      if (req_ready != 0) begin
        if (req_ready[3]) begin grants3++; since3 = 0; end
        else begin since3++; if (since3 > max_since3) max_since3 = since3; end
      end
      tick();
    end
    chk("starve_req3_granted", (grants3 > 0), 1);
    chk("starve_req3_wait", (max_since3 <= NUM_REQ - 1), 1);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      req_valid = 4'($urandom);
      req_a = 4'($urandom); req_b = 4'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1; enable = 0; req_valid = 0;
    repeat (12) tick();
    chk("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
